// File: rtl/uart_doc_reader_if.sv
// Char-stream handshake between uart_doc_reader (master) and html_parser (slave).
interface uart_doc_reader_if #(
  parameter int CHAR_W = 8
);
  logic              pause;
  logic              replay;
  logic              has_finished;
  logic              loading;
  logic [CHAR_W-1:0] char;

  modport master (input pause, replay, output has_finished, loading, char);
  modport slave  (output pause, replay, input has_finished, loading, char);
endinterface

// File: rtl/uart_doc_reader.sv
// UART-loaded document buffer replayed as a pausable char stream for html_parser.
// Define UART_READER_PARITY_EN for 8E1 framing (bad-parity bytes stored as '?'); default is 8N1.
module uart_doc_reader #(
  parameter int         CHAR_W       = 8,
  parameter int         DEPTH        = 4096,
  parameter int         ADDR_W       = 12,
  parameter int         CLKS_PER_BIT = 217,
  parameter logic [7:0] EOT_CHAR     = 8'h04
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                uart_rx,
  uart_doc_reader_if.master   bus,
  output logic                overflow,
  output logic                frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int LEN_W = ADDR_W + 1;

  // ---------------- UART receiver ----------------
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_READER_PARITY_EN
    RX_PAR,
`endif
    RX_STOP
  } rx_state_t;

  rx_state_t        rx_state, rx_nxt;
  logic             rx_meta, rx_sync, rx_prev;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic [7:0]       rx_byte;
  logic             rx_tick, rx_strobe, rx_ferr;
`ifdef UART_READER_PARITY_EN
  logic             rx_par;
`endif

  always_comb begin
    rx_nxt    = rx_state;
    rx_strobe = 1'b0;
    rx_ferr   = 1'b0;
    rx_byte   = rx_shift;
    // start bit is rechecked at mid-bit, every later bit a full period apart
    rx_tick   = (rx_state == RX_START) ? (rx_cnt == CNT_W'(HALF - 1))
                                       : (rx_cnt == CNT_W'(CLKS_PER_BIT - 1));
`ifdef UART_READER_PARITY_EN
    if ((^rx_shift) != rx_par) rx_byte = 8'h3F;
`endif
    case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_sync) rx_nxt = RX_START;
      RX_START: if (rx_tick) rx_nxt = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_bit == 3'd7) begin
`ifdef UART_READER_PARITY_EN
                  rx_nxt = RX_PAR;
`else
                  rx_nxt = RX_STOP;
`endif
                end
`ifdef UART_READER_PARITY_EN
      RX_PAR:   if (rx_tick) rx_nxt = RX_STOP;
`endif
      RX_STOP:  if (rx_tick) begin
                  rx_nxt    = RX_IDLE;
                  rx_strobe = rx_sync;
                  rx_ferr   = !rx_sync;
                end
      default:  rx_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
`ifdef UART_READER_PARITY_EN
      rx_par   <= 1'b0;
`endif
    end else begin
      rx_meta  <= uart_rx;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      rx_state <= rx_nxt;
      rx_cnt   <= (rx_state == RX_IDLE || rx_tick) ? '0 : rx_cnt + 1'b1;
      if (rx_state == RX_DATA && rx_tick) begin
        rx_shift <= {rx_sync, rx_shift[7:1]};
        rx_bit   <= rx_bit + 3'd1;
      end
`ifdef UART_READER_PARITY_EN
      if (rx_state == RX_PAR && rx_tick) rx_par <= rx_sync;
`endif
    end
  end

  // ---------------- Document buffer and stream FSM ----------------
  typedef enum logic [1:0] {LOAD, PRIME, PLAY, DONE} state_t;

  state_t            state, state_nxt;
  logic [CHAR_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_addr;
  logic [LEN_W-1:0]  rd_ptr, length;
  logic [CHAR_W-1:0] char_q;
  logic              fin_q, loading_q;
  logic              is_eot, mem_we, last_slot;

  always_comb begin
    state_nxt = state;
    is_eot    = rx_strobe && (rx_byte == EOT_CHAR);
    mem_we    = (state == LOAD) && rx_strobe && !is_eot;
    last_slot = (wr_ptr == ADDR_W'(DEPTH - 1));
    // read address muxed so mem[rd_ptr] is ready the same cycle it is consumed
    rd_addr   = (state == PRIME) ? '0 : rd_ptr[ADDR_W-1:0];
    case (state)
      LOAD:    if (is_eot)                  state_nxt = (wr_ptr != '0) ? PRIME : DONE;
               else if (mem_we && last_slot) state_nxt = PRIME;
      PRIME:   state_nxt = PLAY;
      PLAY:    if (!bus.pause && rd_ptr == length) state_nxt = DONE;
      DONE:    if (bus.replay && length != '0) state_nxt = PRIME;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem[wr_ptr] <= CHAR_W'(rx_byte);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= LOAD;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      length    <= '0;
      char_q    <= '0;
      fin_q     <= 1'b0;
      loading_q <= 1'b1;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      loading_q <= (state == LOAD) && (state_nxt != DONE);
      if (rx_ferr) frame_err <= 1'b1;
      case (state)
        LOAD: begin
          if (mem_we) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (last_slot) begin
              length   <= LEN_W'(DEPTH);
              overflow <= 1'b1;
            end
          end
          if (is_eot) length <= {1'b0, wr_ptr};
          if (state_nxt == DONE) fin_q <= 1'b1;
        end
        PRIME: begin
          char_q <= mem[rd_addr];
          rd_ptr <= LEN_W'(1);
        end
        PLAY: if (!bus.pause) begin
          if (rd_ptr < length) begin
            char_q <= mem[rd_addr];
            rd_ptr <= rd_ptr + 1'b1;
          end else begin
            char_q <= '0;
            fin_q  <= 1'b1;
          end
        end
        DONE: if (bus.replay && length != '0) fin_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.char         = char_q;
  assign bus.has_finished = fin_q;
  assign bus.loading      = loading_q;

endmodule

// File: tb/tb_uart_doc_reader.sv
// Directed bench for uart_doc_reader with CLKS_PER_BIT=4, DEPTH=8.
module tb_uart_doc_reader;
  localparam int CPB = 4;

  logic clock, reset, uart_rx, overflow, frame_err;
  int   checks = 0;
  int   errors = 0;

  uart_doc_reader_if #(.CHAR_W(8)) bus ();

  uart_doc_reader #(
    .CHAR_W(8), .DEPTH(8), .ADDR_W(3), .CLKS_PER_BIT(CPB), .EOT_CHAR(8'h04)
  ) dut (
    .clock(clock), .reset(reset), .uart_rx(uart_rx),
    .bus(bus), .overflow(overflow), .frame_err(frame_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Leaves the line high at the start of the stop bit so callers can watch the strobe.
  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    uart_rx = 1'b1; repeat (8) @(negedge clock);
    uart_rx = 1'b0; repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i]; repeat (CPB) @(negedge clock);
    end
`ifdef UART_READER_PARITY_EN
    uart_rx = ^b; repeat (CPB) @(negedge clock);
`endif
    if (bad_stop) begin
      uart_rx = 1'b0; repeat (CPB) @(negedge clock);
    end
    uart_rx = 1'b1;
  endtask

  task automatic wait_for(input string tag, input bit want_fin);
    int n = 0;
    while (n < 300 && (want_fin ? (bus.has_finished !== 1'b1) : (bus.loading !== 1'b0))) begin
      @(negedge clock);
      n++;
    end
    chk(tag, 32'(n < 300), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1; repeat (2) @(negedge clock);
    reset = 1'b0; @(negedge clock);
  endtask

  task automatic pulse_replay();
    bus.replay = 1'b1; @(negedge clock);
    bus.replay = 1'b0;
  endtask

  initial begin
    reset = 1'b1; uart_rx = 1'b1; bus.pause = 1'b0; bus.replay = 1'b0;
    do_reset();
    chk("rst_loading", bus.loading, 1);
    chk("rst_char", bus.char, 0);
    chk("rst_fin", bus.has_finished, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ferr", frame_err, 0);

    // "<p>" + EOT, free-running stream
    send_byte(8'h3C, 0); send_byte(8'h70, 0); send_byte(8'h3E, 0); send_byte(8'h04, 0);
    wait_for("p_prime_to", 0);
    chk("p_c0", bus.char, 8'h3C);
    @(negedge clock); chk("p_c1", bus.char, 8'h70);
    @(negedge clock); chk("p_c2", bus.char, 8'h3E);
    chk("p_fin_early", bus.has_finished, 0);
    @(negedge clock); chk("p_fin", bus.has_finished, 1);
    chk("p_end_char", bus.char, 0);
    repeat (3) @(negedge clock);
    chk("p_done_hold", bus.char, 0);

    // replay with pause held on 0x70
    pulse_replay();
    chk("rp_fin_clr", bus.has_finished, 0);
    @(negedge clock); chk("rp_c0", bus.char, 8'h3C);
    @(negedge clock); chk("rp_c1", bus.char, 8'h70);
    bus.pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock); chk("rp_hold", bus.char, 8'h70);
    end
    bus.pause = 1'b0;
    @(negedge clock); chk("rp_c2", bus.char, 8'h3E);
    @(negedge clock); chk("rp_fin", bus.has_finished, 1);
    chk("rp_end_char", bus.char, 0);

    // plain replay gives the same sequence
    pulse_replay();
    @(negedge clock); chk("r2_c0", bus.char, 8'h3C);
    @(negedge clock); chk("r2_c1", bus.char, 8'h70);
    @(negedge clock); chk("r2_c2", bus.char, 8'h3E);
    @(negedge clock); chk("r2_fin", bus.has_finished, 1);

    // reset mid-PLAY
    pulse_replay();
    @(negedge clock); chk("mp_c0", bus.char, 8'h3C);
    reset = 1'b1; bus.replay = 1'b1;
    @(negedge clock);
    chk("mp_loading", bus.loading, 1);
    chk("mp_char", bus.char, 0);
    chk("mp_fin", bus.has_finished, 0);
    reset = 1'b0; bus.replay = 1'b0;
    @(negedge clock);
    chk("mp_still_load", bus.loading, 1);

    // EOT only: straight to DONE, replay ignored
    send_byte(8'h04, 0);
    wait_for("e_fin_to", 1);
    chk("e_char", bus.char, 0);
    chk("e_loading", bus.loading, 0);
    pulse_replay();
    repeat (2) @(negedge clock);
    chk("e_rp_fin", bus.has_finished, 1);
    chk("e_rp_char", bus.char, 0);

    // overflow: 10 bytes into an 8-deep buffer
    do_reset();
    bus.pause = 1'b1;
    for (int i = 0; i < 7; i++) send_byte(8'h41 + 8'(i), 0);
    repeat (8) @(negedge clock);
    chk("o_ovf_7", overflow, 0);
    send_byte(8'h48, 0);
    repeat (8) @(negedge clock);
    chk("o_ovf_8", overflow, 1);
    chk("o_loading", bus.loading, 0);
    send_byte(8'h49, 0); send_byte(8'h4A, 0); send_byte(8'h04, 0);
    repeat (8) @(negedge clock);
    chk("o_c0", bus.char, 8'h41);
    bus.pause = 1'b0;
    for (int i = 1; i < 8; i++) begin
      @(negedge clock); chk("o_cn", bus.char, 8'h41 + 32'(i));
    end
    @(negedge clock); chk("o_fin", bus.has_finished, 1);
    chk("o_end_char", bus.char, 0);

    // framing error on byte 2 of "ab c"
    do_reset();
    bus.pause = 1'b1;
    send_byte(8'h61, 0);
    repeat (8) @(negedge clock);
    chk("f_ferr_0", frame_err, 0);
    send_byte(8'h62, 1);
    repeat (8) @(negedge clock);
    chk("f_ferr_1", frame_err, 1);
    send_byte(8'h20, 0); send_byte(8'h63, 0); send_byte(8'h04, 0);
    wait_for("f_prime_to", 0);
    chk("f_c0", bus.char, 8'h61);
    bus.pause = 1'b0;
    @(negedge clock); chk("f_c1", bus.char, 8'h20);
    @(negedge clock); chk("f_c2", bus.char, 8'h63);
    @(negedge clock); chk("f_fin", bus.has_finished, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
